alarm_controller: RTL and testbench

- Sequences the alarm path of the digital clock. It compares running time against the stored alarm time and decides when to ring.
- Drives the buzzer beep pattern and handles snooze/stop buttons, ring timeout and the snooze limit.
- Sits beside the mode FSM:
  - consumes its `alarmon` (editing not in progress) as `al_idle`;
  - consumes the timekeeper's hour/min/sec and the 1 Hz enable.

---
 rtl/alarm_controller.sv | 129 ++++++++++++
 tb/tb_alarm_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencer: detects the alarm minute, rings with a 1 s on/off beep,
// and handles snooze, stop, ring timeout and the per-event snooze limit.
module alarm_controller #(
   parameter int unsigned SNOOZE_MIN     = 5,
   parameter int unsigned RING_TIMEOUT_S = 60,
   parameter int unsigned MAX_SNOOZE     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [4:0] al_hour,
   input  logic [5:0] al_min,
   input  logic       armed,
   input  logic       al_idle,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       ringing,
   output logic       buzzer,
   output logic       snoozing,
   output logic [2:0] snooze_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RING   = 2'd1;
   localparam logic [1:0] SNOOZE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [7:0] RING_LOAD = 8'(RING_TIMEOUT_S);
   localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
   localparam logic [2:0] SNZ_LIMIT = 3'(MAX_SNOOZE);

   logic [1:0] state_q, state_d;
   logic [7:0] ring_timer_q, ring_timer_d;
   logic [9:0] snz_timer_q, snz_timer_d;
   logic       beep_phase_q, beep_phase_d;
   logic [2:0] snooze_cnt_q, snooze_cnt_d;

   logic match;
   logic abort;
   logic ring_expire;

   assign match       = (cur_hour == al_hour) && (cur_min == al_min);
   assign abort       = !armed || !al_idle;
   assign ring_expire = tick_1hz && (ring_timer_q == 8'd1);

   always_comb begin
      state_d      = state_q;
      ring_timer_d = ring_timer_q;
      snz_timer_d  = snz_timer_q;
      beep_phase_d = beep_phase_q;
      snooze_cnt_d = snooze_cnt_q;

      if (state_q != IDLE && abort) begin
         state_d      = IDLE;
         snooze_cnt_d = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (armed && al_idle && match && cur_sec == 6'd0) begin
                  state_d      = RING;
                  ring_timer_d = RING_LOAD;
                  beep_phase_d = 1'b1;
                  snooze_cnt_d = 3'd0;
               end
            end
            RING: begin
               if (stop_btn) begin
                  state_d = DONE;
               end else if (snooze_btn || ring_expire) begin
                  // Once the snooze budget is spent, a snooze or timeout ends the event.
                  if (snooze_cnt_q < SNZ_LIMIT) begin
                     state_d      = SNOOZE;
                     snz_timer_d  = SNZ_LOAD;
                     snooze_cnt_d = snooze_cnt_q + 3'd1;
                  end else begin
                     state_d = DONE;
                  end
               end else if (tick_1hz) begin
                  beep_phase_d = !beep_phase_q;
                  if (ring_timer_q != 8'd0) ring_timer_d = ring_timer_q - 8'd1;
               end
            end
            SNOOZE: begin
               if (stop_btn) begin
                  state_d = DONE;
               end else if (tick_1hz && snz_timer_q == 10'd1) begin
                  state_d      = RING;
                  ring_timer_d = RING_LOAD;
                  beep_phase_d = 1'b1;
               end else if (tick_1hz && snz_timer_q != 10'd0) begin
                  snz_timer_d = snz_timer_q - 10'd1;
               end
            end
            default: begin
               // Leaving only once the minute has moved on blocks a re-trigger.
               if (!match) begin
                  state_d      = IDLE;
                  snooze_cnt_d = 3'd0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ring_timer_q <= 8'd0;
         snz_timer_q  <= 10'd0;
         beep_phase_q <= 1'b0;
         snooze_cnt_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         ring_timer_q <= ring_timer_d;
         snz_timer_q  <= snz_timer_d;
         beep_phase_q <= beep_phase_d;
         snooze_cnt_q <= snooze_cnt_d;
      end
   end

   assign ringing    = (state_q == RING);
   assign buzzer     = (state_q == RING) && beep_phase_q;
   assign snoozing   = (state_q == SNOOZE);
   assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with SNOOZE_MIN=1, RING_TIMEOUT_S=4, MAX_SNOOZE=2.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_1hz;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic [4:0] al_hour;
   logic [5:0] al_min;
   logic       armed;
   logic       al_idle;
   logic       snooze_btn;
   logic       stop_btn;
   logic       ringing;
   logic       buzzer;
   logic       snoozing;
   logic [2:0] snooze_cnt;

   int testCount = 0;
   int failCount = 0;

   alarm_controller #(
      .SNOOZE_MIN(1),
      .RING_TIMEOUT_S(4),
      .MAX_SNOOZE(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tick_1hz(tick_1hz),
      .cur_hour(cur_hour),
      .cur_min(cur_min),
      .cur_sec(cur_sec),
      .al_hour(al_hour),
      .al_min(al_min),
      .armed(armed),
      .al_idle(al_idle),
      .snooze_btn(snooze_btn),
      .stop_btn(stop_btn),
      .ringing(ringing),
      .buzzer(buzzer),
      .snoozing(snoozing),
      .snooze_cnt(snooze_cnt)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Holds the given pulses for one rising edge, then samples 1 time unit later.
   task automatic applyStimulus(input logic snz, input logic stp, input logic tk);
      snooze_btn = snz;
      stop_btn   = stp;
      tick_1hz   = tk;
      @(posedge clk);
      #1;
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
      tick_1hz   = 1'b0;
   endtask

   task automatic setTime(input int h, input int m, input int s);
      cur_hour = 5'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
   endtask

   task automatic checkAll(input string tag, input logic r, input logic b, input logic s, input logic [2:0] c);
      checkOutput({tag, ".ringing"}, ringing, r);
      checkOutput({tag, ".buzzer"}, buzzer, b);
      checkOutput({tag, ".snoozing"}, snoozing, s);
      checkOutput({tag, ".snooze_cnt"}, snooze_cnt, c);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; armed = 1'b1; al_idle = 1'b1;
      snooze_btn = 1'b0; stop_btn = 1'b0; tick_1hz = 1'b0;
      al_hour = 5'd7; al_min = 6'd30;
      setTime(7, 29, 59);
      #1;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkAll("reset", 0, 0, 0, 3'd0);
      reset = 1'b0;

      // Trigger and beep pattern
      applyStimulus(0, 0, 0);
      checkOutput("pre_match.ringing", ringing, 0);
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      checkAll("trigger", 1, 1, 0, 3'd0);
      ticks(1);
      checkAll("beep_off", 1, 0, 0, 3'd0);
      ticks(1);
      checkAll("beep_on", 1, 1, 0, 3'd0);

      // Manual snooze, re-ring after 60 ticks, limit reached
      applyStimulus(1, 0, 0);
      checkAll("snooze1", 0, 0, 1, 3'd1);
      ticks(59);
      checkAll("snooze1_59", 0, 0, 1, 3'd1);
      ticks(1);
      checkAll("rering1", 1, 1, 0, 3'd1);
      applyStimulus(1, 0, 0);
      checkAll("snooze2", 0, 0, 1, 3'd2);
      ticks(60);
      checkAll("rering2", 1, 1, 0, 3'd2);
      applyStimulus(1, 0, 0);
      checkAll("limit_done", 0, 0, 0, 3'd2);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkAll("done_hold", 0, 0, 0, 3'd2);
      setTime(7, 31, 0);
      applyStimulus(0, 0, 0);
      checkAll("done_exit", 0, 0, 0, 3'd0);

      // Timeout auto-snooze, then simultaneous stop+snooze
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      checkAll("trigger2", 1, 1, 0, 3'd0);
      ticks(3);
      checkAll("timeout_pre", 1, 0, 0, 3'd0);
      ticks(1);
      checkAll("timeout_snz", 0, 0, 1, 3'd1);
      applyStimulus(1, 0, 0);
      checkAll("snz_ignored", 0, 0, 1, 3'd1);
      ticks(60);
      checkAll("rering3", 1, 1, 0, 3'd1);
      applyStimulus(1, 1, 0);
      checkAll("stop_wins", 0, 0, 0, 3'd1);

      // Stop, no re-trigger within the minute, re-arm after it
      setTime(7, 31, 0);
      applyStimulus(0, 0, 0);
      checkOutput("idle_again.snooze_cnt", snooze_cnt, 3'd0);
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      checkOutput("trigger3.ringing", ringing, 1);
      applyStimulus(0, 1, 0);
      checkAll("stop", 0, 0, 0, 3'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("no_retrigger.ringing", ringing, 0);
      setTime(7, 31, 0);
      applyStimulus(0, 0, 0);
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      checkOutput("was_idle.ringing", ringing, 1);

      // Abort from RING
      armed = 1'b0;
      setTime(7, 30, 1);
      applyStimulus(0, 0, 0);
      checkAll("abort_ring", 0, 0, 0, 3'd0);
      armed = 1'b1;
      applyStimulus(0, 0, 0);
      checkOutput("abort_idle.ringing", ringing, 0);

      // Abort from SNOOZE clears the count
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("abort_pre.snooze_cnt", snooze_cnt, 3'd1);
      al_idle = 1'b0;
      applyStimulus(0, 0, 0);
      checkAll("abort_snz", 0, 0, 0, 3'd0);

      // Editing in progress at the alarm instant: no trigger
      setTime(7, 29, 59);
      applyStimulus(0, 0, 0);
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("edit_block.ringing", ringing, 0);

      // Arming partway through the minute: no trigger
      al_idle = 1'b1;
      armed = 1'b0;
      setTime(7, 30, 20);
      applyStimulus(0, 0, 0);
      armed = 1'b1;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("late_arm.ringing", ringing, 0);

      // Reset mid-snooze
      setTime(7, 30, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkAll("pre_reset", 0, 0, 1, 3'd1);
      reset = 1'b1;
      applyStimulus(0, 0, 1);
      checkAll("mid_reset", 0, 0, 0, 3'd0);
      setTime(7, 30, 5);
      reset = 1'b0;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      checkAll("post_reset", 0, 0, 0, 3'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
